// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, write-back source mux, retire counter; WB_FWD_EN adds EX-stage bypass outputs
module wb_stage #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic              in_wb_en,
    input  logic [2:0]        in_wb_sel,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [15:0]       in_imm16,
    input  logic [DATA_W-1:0] in_rd_old,
    output logic              rf_en,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_data,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [31:0]       retired_count,
    output logic              bad_rd
);
    logic              valid_q, done_q, wb_en_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] data_q, old, src_data;
    logic [PC_W-1:0]   pc_inc;
    logic              src_wb_en, legal, capture;

    // source select; the merge base bypasses the write in flight so back-to-back LCL/LCH compose
    always_comb begin
        pc_inc    = in_pc + PC_W'(1);
        old       = (rf_en && rf_rd == in_rd) ? rf_data : in_rd_old;
        src_data  = in_wb_sel == 3'd0 ? in_alu_result :
                    in_wb_sel == 3'd1 ? in_mem_data :
                    in_wb_sel == 3'd2 ? DATA_W'(pc_inc) :
                    in_wb_sel == 3'd3 ? {old[DATA_W-1:16], in_imm16} :
                    in_wb_sel == 3'd4 ? {in_imm16, old[15:0]} : '0;
        src_wb_en = in_wb_en & (in_wb_sel <= 3'd4);
        capture   = ~in_stall | in_flush;
        legal     = 32'(rd_q) < NUM_REGS;
    end

    // pipeline register: capture unless stalled (flush forces a bubble); a held entry is marked done after its first cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (capture) begin
            valid_q <= in_valid & ~in_flush;
            done_q  <= 1'b0;
            wb_en_q <= src_wb_en;
            rd_q    <= in_rd;
            data_q  <= src_data;
        end else begin
            done_q  <= done_q | valid_q;
        end
    end

    // retire each entry once and remember any write aimed at a nonexistent register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_count <= '0;
            bad_rd        <= 1'b0;
        end else begin
            if (valid_q && !done_q) retired_count <= retired_count + 32'd1;
            if (valid_q && wb_en_q && !legal) bad_rd <= 1'b1;
        end
    end

    assign rf_en   = valid_q & wb_en_q & ~done_q & legal;
    assign rf_rd   = rd_q;
    assign rf_data = data_q;

`ifdef WB_FWD_EN
    assign fwd_valid = valid_q & wb_en_q & legal;
    assign fwd_rd    = rd_q;
    assign fwd_data  = data_q;
`else
    // without forwarding the EX stage sees results only through the register file
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; forwarding outputs are checked when WB_FWD_EN is defined
module tb_wb_stage;
    logic        clk, rst;
    logic        in_valid, in_stall, in_flush, in_wb_en;
    logic [2:0]  in_wb_sel;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result, in_mem_data, in_pc, in_rd_old;
    logic [15:0] in_imm16;
    logic        rf_en, bad_rd;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data, retired_count;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_ret  = 0;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_stall(in_stall), .in_flush(in_flush),
        .in_wb_en(in_wb_en), .in_wb_sel(in_wb_sel), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc(in_pc),
        .in_imm16(in_imm16), .in_rd_old(in_rd_old),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
`ifdef WB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .retired_count(retired_count), .bad_rd(bad_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_stall = 0; in_flush = 0; in_wb_en = 0; in_wb_sel = 0; in_rd = 0;
        in_alu_result = 0; in_mem_data = 0; in_pc = 0; in_imm16 = 0; in_rd_old = 0;
    endtask

    task automatic issue(input logic wb_en, input logic [2:0] sel, input logic [4:0] rd);
        in_valid = 1; in_wb_en = wb_en; in_wb_sel = sel; in_rd = rd;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rf_en) begin
            if (sb.size() == 0) check("unexpected_write", {27'd0, rf_rd}, 64'hFFFF);
            else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_rd", {59'd0, rf_rd}, {59'd0, e.rd});
                check("wr_data", {32'd0, rf_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        idle();
        rst = 0;
        #1;
        check("rst_rf_en", rf_en, 0);
        check("rst_rf_data", rf_data, 0);
        check("rst_retired", retired_count, 0);
        check("rst_bad_rd", bad_rd, 0);
        @(negedge clk);
        rst = 1;
        tick();

        issue(1, 0, 5); in_alu_result = 32'hDEADBEEF; push(5, 32'hDEADBEEF);
        tick();
        check("alu_en", rf_en, 1);
        idle();
        tick();
        check("alu_one_cycle", rf_en, 0);
        check("alu_retired", retired_count, exp_ret);

        issue(1, 2, 15); in_pc = 32'h40; push(15, 32'h41);
        tick();
        check("jal_en", rf_en, 1);
        idle();
        in_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jal_stall_en", rf_en, 0);
            check("jal_stall_rd", rf_rd, 15);
            check("jal_stall_data", rf_data, 32'h41);
`ifdef WB_FWD_EN
            check("fwd_valid_stall", fwd_valid, 1);
            check("fwd_rd_stall", fwd_rd, 15);
            check("fwd_data_stall", fwd_data, 32'h41);
`endif
        end
        check("jal_retired_once", retired_count, exp_ret);
        idle();
        tick();

        issue(1, 1, 0); in_mem_data = 32'h12345678; push(0, 32'h12345678);
        tick();
        idle();
        issue(1, 5, 4); in_alu_result = 32'hFFFF;
        tick();
        check("rsv_no_write", rf_en, 0);

        idle();
        issue(1, 3, 3); in_imm16 = 16'hAAAA; in_rd_old = 32'h11112222; push(3, 32'h1111AAAA);
        tick();
        issue(1, 4, 3); in_imm16 = 16'hBBBB; in_rd_old = 32'h11112222; push(3, 32'hBBBBAAAA);
        tick();
        idle();
        tick();
        check("lc_retired", retired_count, exp_ret);

        in_valid = 1; in_flush = 1; in_stall = 1; in_wb_en = 1; in_rd = 7; in_alu_result = 32'h77;
        tick();
        check("flush_no_write", rf_en, 0);
        idle();
        tick();
        check("flush_retired", retired_count, exp_ret);
        check("flush_bad_rd", bad_rd, 0);

        issue(1, 0, 16); in_alu_result = 32'h16;
        tick();
        check("rd16_no_write", rf_en, 0);
        idle();
        tick();
        check("rd16_bad_rd", bad_rd, 1);
        issue(1, 0, 20); in_alu_result = 32'h1;
        tick();
        check("rd20_no_write", rf_en, 0);
        idle();
        repeat (3) tick();
        issue(1, 0, 1); in_alu_result = 32'h55; push(1, 32'h55);
        tick();
        idle();
        tick();
        check("bad_sticky", bad_rd, 1);
        check("bad_retired", retired_count, exp_ret);

        issue(1, 0, 2); in_alu_result = 32'h99;
        tick();
        idle();
        in_stall = 1;
        rst = 0;
        #1;
        check("mid_rst_rf_en", rf_en, 0);
        check("mid_rst_rf_rd", rf_rd, 0);
        check("mid_rst_rf_data", rf_data, 0);
        check("mid_rst_retired", retired_count, 0);
        check("mid_rst_bad_rd", bad_rd, 0);
        exp_ret = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        idle();
        tick();
        check("post_rst_idle", rf_en, 0);
        issue(1, 0, 9); in_alu_result = 32'hCAFEF00D; push(9, 32'hCAFEF00D);
        tick();
        check("post_rst_en", rf_en, 1);
        idle();
        tick();
        check("post_rst_retired", retired_count, exp_ret);

        force dut.retired_count = 32'hFFFFFFFF;
        #1;
        release dut.retired_count;
        exp_ret = 32'hFFFFFFFF;
        check("wrap_pre", retired_count, exp_ret);
        issue(0, 0, 0);
        tick();
        check("nowb_no_write", rf_en, 0);
        idle();
        tick();
        check("wrap", retired_count, 0);
        check("wrap_model", retired_count, exp_ret);

        repeat (2) tick();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back source mux for core_lapido.
- Drives the general-purpose register file's single write port (en, rd, data).
- Generates the JAL link value and the LCL/LCH 16-bit half-word merges.
- Counts retired instructions and flags writes to nonexistent registers.

Parameters:
DATA_W, 32, GPR width (matches register file data width)
PC_W, 32, program counter width
NUM_REGS, 16, number of implemented GPRs; rd >= NUM_REGS is illegal

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream presents an instruction
in_stall  in  1  hold current stage contents
in_flush  in  1  discard instruction being captured
in_wb_en  in  1  instruction writes a GPR
in_wb_sel  in  3  source: 0 ALU, 1 MEM, 2 LINK, 3 LCL, 4 LCH, 5-7 reserved
in_rd  in  5  destination register
in_alu_result  in  DATA_W  ALU result
in_mem_data  in  DATA_W  load data
in_pc  in  PC_W  address of the instruction
in_imm16  in  16  immediate for LCL/LCH
in_rd_old  in  DATA_W  current register-file value of in_rd
rf_en  out  1  register file write enable
rf_rd  out  5  register file write address
rf_data  out  DATA_W  register file write data
retired_count  out  32  retired-instruction counter
bad_rd  out  1  sticky illegal-destination flag

Behaviour:
- Reset (rst=0, async):
  - valid_q, done_q, retired_count, bad_rd and all stored fields clear to 0.
  - Hence rf_en=0, rf_rd=0, rf_data=0.
- Capture: on each clk edge with in_stall=0:
  - valid_q <= in_valid & ~in_flush.
  - All fields are latched.
  - done_q <= 0.
- Flush priority:
  - in_flush=1 overrides in_stall.
  - valid_q <= 0 on that edge; stored fields are don't-care.
- Source data is computed at capture and stored as data_q:
  - ALU: in_alu_result.
  - MEM: in_mem_data.
  - LINK: in_pc + 1, zero-extended or truncated to DATA_W.
  - LCL: {old[DATA_W-1:16], in_imm16}.
  - LCH: {in_imm16, old[15:0]}.
  - Reserved codes: data 0, and the write is suppressed (treated as wb_en=0).
- Merge hazard: "old" is rf_data whenever rf_en=1 in the capture cycle and rf_rd==in_rd; otherwise it is in_rd_old. This lets back-to-back LCL/LCH to the same rd compose correctly.
- Write: rf_en = valid_q & wb_en_q & ~done_q & (rd_q < NUM_REGS).
  - rf_rd = rd_q; rf_data = data_q.
  - Latency: exactly one cycle from capture edge to rf_en.
- Single write per entry:
  - done_q sets on the edge after the entry is first presented, so a stalled entry writes exactly once.
  - rf_rd and rf_data remain stable while stalled.
- Retire:
  - retired_count += 1 on the first cycle of each valid entry (valid_q & ~done_q), regardless of wb_en.
  - Wraps 0xFFFFFFFF -> 0.
- Illegal rd: valid_q & wb_en_q & rd_q >= NUM_REGS suppresses the write and sets bad_rd. bad_rd clears only on reset.
- Reset mid-stall:
  - The entry is lost and no write occurs.
  - The first capture after rst deasserts behaves normally.

Optional Feature:
Macro WB_FWD_EN.
- Defined:
  - Adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (DATA_W).
  - fwd_valid = valid_q & wb_en_q & (rd_q < NUM_REGS). It stays high for the entire time the entry is held, including stalled cycles after done_q.
  - fwd_rd = rd_q; fwd_data = data_q. These feed the EX-stage bypass.
- Undefined: the three ports and their logic are absent. Everything else is unchanged.

Test Plan:
- Reset: rst=0 mid-run -> rf_en=0, rf_data=0, retired_count=0, bad_rd=0 immediately, without waiting for a clock edge.
- ALU write: in_valid=1, wb_en=1, sel=0, rd=5, alu=0xDEADBEEF -> next cycle rf_en=1, rf_rd=5, rf_data=0xDEADBEEF for one cycle; retired_count=1.
- JAL: sel=2, pc=0x00000040, rd=15 -> rf_data=0x00000041. Stall held 3 cycles -> rf_en high only on the first cycle, retired_count increments once.
- LCL then LCH back-to-back on rd=3, in_rd_old=0x11112222 (stale), imm 0xAAAA then 0xBBBB -> writes 0x1111AAAA, then 0xBBBBAAAA (bypass used).
- Flush with stall: in_flush=1, in_stall=1, in_valid=1 -> no write, no retire. Also rd=20 with wb_en=1 -> no write, bad_rd=1 and stays 1.
- Counter wrap: preload via 2^32 retires, or force in sim -> 0xFFFFFFFF + 1 retire = 0. With WB_FWD_EN, fwd_valid stays high through a stall while rf_en pulses once.
